// File: rtl/axil_pkg.sv
// Shared AXI-Lite widths, response codes and read-slice types.
// Imported by the read register slice, its interface and its skid buffers.
package axil_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // R-channel beat as carried through the skid buffer: {rresp, rdata}
  typedef struct packed {
    logic [1:0]                resp;
    logic [AXI_DATA_WIDTH-1:0] data;
  } r_beat_t;

  // Occupancy of a skid buffer: main only, or main plus skid
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/axil_reg_slice_rd_if.sv
// AXI-Lite read-path bundle (AR + R). master drives AR and rready,
// slave drives arready and the R beat.
interface axil_reg_slice_rd_if;
  import axil_pkg::*;

  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic                      arvalid;
  logic                      arready;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_skid_buffer.sv
// Two-entry skid buffer: 1 cycle latency, full throughput, in_ready from a
// register (drops the cycle after the skid entry fills), payload held until out_fire.
module axil_skid_buffer
  import axil_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_payload,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_payload,
  output logic             out_valid,
  input  logic             out_ready
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_fire, out_fire;
  logic             load_main_in, load_main_skid, load_skid;

  assign out_valid   = (state_q != SKID_EMPTY);
  assign in_ready    = (state_q != SKID_TWO);
  assign out_payload = main_q;
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (in_fire) begin
          state_d      = SKID_ONE;
          load_main_in = 1'b1;
        end
      end
      SKID_ONE: begin
        if (in_fire && !out_fire) begin
          state_d   = SKID_TWO;
          load_skid = 1'b1;
        end else if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (out_fire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        // in_ready is low here, so only the drain of main can happen
        if (out_fire) begin
          state_d        = SKID_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_payload;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_payload;
      end
    end
  end

endmodule

// File: rtl/axil_reg_slice_rd.sv
// AXI-Lite read register slice: 1 cycle per channel (0 when bypassed),
// full throughput; upstream ready is registered so no ready path crosses the slice.
module axil_reg_slice_rd
  import axil_pkg::*;
#(
  parameter bit AR_BYPASS = 1'b0,
  parameter bit R_BYPASS  = 1'b0
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axil_reg_slice_rd_if.slave   m_axil,
  axil_reg_slice_rd_if.master  s_axil
);

  if (AR_BYPASS) begin : g_ar_bypass
    assign s_axil.araddr  = m_axil.araddr;
    assign s_axil.arvalid = m_axil.arvalid;
    assign m_axil.arready = s_axil.arready;
  end else begin : g_ar_slice
    axil_skid_buffer #(
      .WIDTH (AXI_ADDR_WIDTH)
    ) u_ar (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .in_payload  (m_axil.araddr),
      .in_valid    (m_axil.arvalid),
      .in_ready    (m_axil.arready),
      .out_payload (s_axil.araddr),
      .out_valid   (s_axil.arvalid),
      .out_ready   (s_axil.arready)
    );
  end

  if (R_BYPASS) begin : g_r_bypass
    assign m_axil.rdata  = s_axil.rdata;
    assign m_axil.rresp  = s_axil.rresp;
    assign m_axil.rvalid = s_axil.rvalid;
    assign s_axil.rready = m_axil.rready;
  end else begin : g_r_slice
    r_beat_t r_in, r_out;

    assign r_in.resp     = s_axil.rresp;
    assign r_in.data     = s_axil.rdata;
    assign m_axil.rresp  = r_out.resp;
    assign m_axil.rdata  = r_out.data;

    axil_skid_buffer #(
      .WIDTH ($bits(r_beat_t))
    ) u_r (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .in_payload  (r_in),
      .in_valid    (s_axil.rvalid),
      .in_ready    (s_axil.rready),
      .out_payload (r_out),
      .out_valid   (m_axil.rvalid),
      .out_ready   (m_axil.rready)
    );
  end

  // Fully bypassed slice is pure wiring; clock and reset are intentionally idle
  if (AR_BYPASS && R_BYPASS) begin : g_no_state
    logic unused_clk_rst;
    assign unused_clk_rst = aclk & aresetn;
  end

endmodule

// File: tb/tb_axil_reg_slice_rd.sv
// Directed bench for axil_reg_slice_rd: registered instance plus a fully bypassed one.
module tb_axil_reg_slice_rd;
  import axil_pkg::*;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 aclk = ~aclk;

  axil_reg_slice_rd_if up ();
  axil_reg_slice_rd_if down ();
  axil_reg_slice_rd_if bup ();
  axil_reg_slice_rd_if bdown ();

  axil_reg_slice_rd #(.AR_BYPASS(1'b0), .R_BYPASS(1'b0)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .m_axil  (up),
    .s_axil  (down)
  );

  axil_reg_slice_rd #(.AR_BYPASS(1'b1), .R_BYPASS(1'b1)) dut_byp (
    .aclk    (aclk),
    .aresetn (aresetn),
    .m_axil  (bup),
    .s_axil  (bdown)
  );

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_vec({pfx, "_arready"}, 64'(up.arready), 64'd1);
    check_vec({pfx, "_rready"},  64'(down.rready), 64'd1);
    check_vec({pfx, "_arvalid"}, 64'(down.arvalid), 64'd0);
    check_vec({pfx, "_rvalid"},  64'(up.rvalid), 64'd0);
    check_vec({pfx, "_araddr"},  64'(down.araddr), 64'd0);
    check_vec({pfx, "_rdata"},   64'(up.rdata), 64'd0);
    check_vec({pfx, "_rresp"},   64'(up.rresp), 64'd0);
  endtask

  // One address in, one beat back; each channel adds exactly one cycle
  task automatic single_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    down.arready = 1'b1;
    up.rready    = 1'b1;
    up.araddr    = addr;
    up.arvalid   = 1'b1;
    tick();
    up.arvalid = 1'b0;
    check_vec("rd_arvalid", 64'(down.arvalid), 64'd1);
    check_vec("rd_araddr",  64'(down.araddr), 64'(addr));
    down.rdata  = data;
    down.rresp  = resp;
    down.rvalid = 1'b1;
    check_vec("rd_rvalid_early", 64'(up.rvalid), 64'd0);
    tick();
    down.rvalid = 1'b0;
    check_vec("rd_arvalid_done", 64'(down.arvalid), 64'd0);
    check_vec("rd_rvalid", 64'(up.rvalid), 64'd1);
    check_vec("rd_rdata",  64'(up.rdata), 64'(data));
    check_vec("rd_rresp",  64'(up.rresp), 64'(resp));
    tick();
    check_vec("rd_rvalid_done", 64'(up.rvalid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] pat;
    logic [33:0] held;
    logic        held_vld;
    logic        slv_acc;
    int          idx;
    int          got;

    up.araddr = '0;   up.arvalid = 1'b0; up.rready = 1'b0;
    down.arready = 1'b0; down.rdata = '0; down.rresp = '0; down.rvalid = 1'b0;
    bup.araddr = '0;  bup.arvalid = 1'b0; bup.rready = 1'b0;
    bdown.arready = 1'b0; bdown.rdata = '0; bdown.rresp = '0; bdown.rvalid = 1'b0;

    #1;
    check_reset_outputs("rst");
    tick();
    tick();
    aresetn = 1'b1;

    single_read(32'h0000_0010, 32'hDEAD_BEEF, RESP_OKAY);

    // Streaming: eight addresses, one per cycle, no bubbles
    down.arready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      up.araddr  = 32'(i * 4);
      up.arvalid = 1'b1;
      check_vec("str_arready", 64'(up.arready), 64'd1);
      tick();
      check_vec("str_arvalid", 64'(down.arvalid), 64'd1);
      check_vec("str_araddr",  64'(down.araddr), 64'(i * 4));
    end
    up.arvalid = 1'b0;
    tick();
    check_vec("str_drained", 64'(down.arvalid), 64'd0);

    // AR backpressure: slave stalls four cycles while three addresses are offered
    down.arready = 1'b0;
    up.arvalid = 1'b1;
    up.araddr = 32'h0;
    check_vec("bp_rdy0", 64'(up.arready), 64'd1);
    tick();
    up.araddr = 32'h4;
    check_vec("bp_rdy1", 64'(up.arready), 64'd1);
    tick();
    up.araddr = 32'h8;
    check_vec("bp_rdy2", 64'(up.arready), 64'd0);
    tick();
    check_vec("bp_hold_rdy", 64'(up.arready), 64'd0);
    check_vec("bp_hold_addr0", 64'(down.araddr), 64'h0);
    tick();
    check_vec("bp_hold_addr1", 64'(down.araddr), 64'h0);
    check_vec("bp_hold_vld", 64'(down.arvalid), 64'd1);
    down.arready = 1'b1;
    tick();
    check_vec("bp_out1", 64'(down.araddr), 64'h4);
    check_vec("bp_rdy_back", 64'(up.arready), 64'd1);
    tick();
    up.arvalid = 1'b0;
    check_vec("bp_out2", 64'(down.araddr), 64'h8);
    check_vec("bp_out2_vld", 64'(down.arvalid), 64'd1);
    tick();
    check_vec("bp_empty", 64'(down.arvalid), 64'd0);

    // R stall: upstream rready follows a fixed irregular pattern
    pat = 16'b0011_0101_1001_0110;
    held = '0;
    held_vld = 1'b0;
    idx = 0;
    got = 0;
    down.rvalid = 1'b1;
    down.rresp  = RESP_SLVERR;
    down.rdata  = 32'hA000_0000;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      up.rready = pat[cyc % 16];
      if (held_vld) begin
        check_vec("rs_stable", 64'({up.rresp, up.rdata}), 64'(held));
      end
      if (up.rvalid && up.rready) begin
        check_vec("rs_data", 64'(up.rdata), 64'(32'hA000_0000 + 32'(got)));
        check_vec("rs_resp", 64'(up.rresp), 64'(RESP_SLVERR));
        got++;
        held_vld = 1'b0;
      end else if (up.rvalid && !held_vld) begin
        held_vld = 1'b1;
        held = {up.rresp, up.rdata};
      end
      slv_acc = down.rvalid && down.rready;
      tick();
      if (slv_acc) begin
        idx++;
        if (idx < 8) begin
          down.rdata = 32'hA000_0000 + 32'(idx);
        end else begin
          down.rvalid = 1'b0;
        end
      end
    end
    check_vec("rs_count", 64'(got), 64'd8);
    up.rready = 1'b1;
    tick();
    check_vec("rs_no_dup", 64'(up.rvalid), 64'd0);

    // Fill both channels to two entries, then reset asynchronously
    down.arready = 1'b0;
    up.rready    = 1'b0;
    up.arvalid   = 1'b1;
    up.araddr    = 32'h100;
    down.rvalid  = 1'b1;
    down.rresp   = RESP_OKAY;
    down.rdata   = 32'h1;
    tick();
    up.araddr  = 32'h104;
    down.rdata = 32'h2;
    tick();
    up.arvalid  = 1'b0;
    down.rvalid = 1'b0;
    check_vec("full_arready", 64'(up.arready), 64'd0);
    check_vec("full_rready",  64'(down.rready), 64'd0);
    check_vec("full_rdata",   64'(up.rdata), 64'h1);
    #2;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("mrst");
    tick();
    aresetn = 1'b1;
    single_read(32'h0000_0020, 32'h1234_5678, RESP_OKAY);

    // Bypass instance: pure wiring, checked without any clock edge
    bup.araddr = 32'h0000_ABCD;
    bup.arvalid = 1'b1;
    bdown.arready = 1'b0;
    #1;
    check_vec("byp_araddr",  64'(bdown.araddr), 64'h0000_ABCD);
    check_vec("byp_arvalid", 64'(bdown.arvalid), 64'd1);
    check_vec("byp_arready0", 64'(bup.arready), 64'd0);
    bdown.arready = 1'b1;
    #1;
    check_vec("byp_arready1", 64'(bup.arready), 64'd1);
    bdown.rdata = 32'h0000_55AA;
    bdown.rresp = RESP_DECERR;
    bdown.rvalid = 1'b1;
    bup.rready = 1'b0;
    #1;
    check_vec("byp_rdata",  64'(bup.rdata), 64'h0000_55AA);
    check_vec("byp_rresp",  64'(bup.rresp), 64'(RESP_DECERR));
    check_vec("byp_rvalid", 64'(bup.rvalid), 64'd1);
    check_vec("byp_rready0", 64'(bdown.rready), 64'd0);
    bup.rready = 1'b1;
    #1;
    check_vec("byp_rready1", 64'(bdown.rready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
